flanger_ctrl: RTL and testbench

- Sequencer and scheduler for the flanger's shared dual-port delay-line RAM (8-bit samples, 13-bit addresses).
- Per accepted ADC sample, in a fixed slot order:
  - one write on port A;
  - two time-multiplexed reads on port B: swept tap delay1, then fixed tap delay2.
- Generates the triangle sweep of the delay1 offset between programmable limits.
- Flags samples dropped while busy.

---
 rtl/flanger_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_flanger_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flanger_ctrl.sv
// flanger_ctrl: per-sample sequencer for the flanger delay-line RAM.
// Each accepted ADC sample gets one port-A write followed by two port-B
// reads (swept tap, then fixed tap). The swept-tap offset follows a
// triangle between programmable limits, stepping once every sweep_div+1
// samples.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | waiting for an enabled rising edge of data_rdy
//   S_WRITE | drive port-A write of the latched sample at wr_ptr
//   S_RD1   | end write, present swept-tap address wr_ptr-offset
//   S_RD2   | present fixed-tap address wr_ptr-par_delay2
//   S_CAP1  | capture swept-tap read data
//   S_CAP2  | capture fixed-tap data, advance wr_ptr, step sweep, pulse valid
module flanger_ctrl #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              data_rdy,
    input  logic [DATA_W-1:0] data_adc,
    input  logic [ADDR_W-1:0] par_delay2,
    input  logic [ADDR_W-1:0] offset_lowlimit,
    input  logic [ADDR_W-1:0] offset_uplimit,
    input  logic [DIV_W-1:0]  sweep_div,
    output logic              we_a,
    output logic [ADDR_W-1:0] adr_a,
    output logic [DATA_W-1:0] dat_a,
    output logic [ADDR_W-1:0] adr_b,
    input  logic [DATA_W-1:0] dat_b,
    output logic [DATA_W-1:0] realt,
    output logic [DATA_W-1:0] delay1,
    output logic [DATA_W-1:0] delay2,
    output logic [ADDR_W-1:0] offset,
    output logic              sample_valid,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RD1   = 3'd2,
        S_RD2   = 3'd3,
        S_CAP1  = 3'd4,
        S_CAP2  = 3'd5
    } state_t;

    state_t              state;
    logic                data_rdy_q;
    logic                rise;
    logic [DATA_W-1:0]   sample;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [DIV_W-1:0]    div_cnt;
    logic                dir;
    logic [ADDR_W-1:0]   offset_step;
    logic                dir_step;

    assign rise = data_rdy & ~data_rdy_q;
    assign busy = (state != S_IDLE);

    // Register data_rdy every cycle so a level held high yields one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_rdy_q <= 1'b0;
        end else begin
            data_rdy_q <= data_rdy;
        end
    end

    // One triangle step; only applied when the divider reaches sweep_div.
    // Out-of-range offsets snap to the nearest limit so limit changes are
    // picked up on the next step without glitching the direction.
    always_comb begin
        offset_step = offset;
        dir_step    = dir;
        if (offset_lowlimit > offset_uplimit) begin
            offset_step = offset_lowlimit;
            dir_step    = 1'b1;
        end else if (offset < offset_lowlimit) begin
            offset_step = offset_lowlimit;
            dir_step    = 1'b1;
        end else if (offset > offset_uplimit) begin
            offset_step = offset_uplimit;
            dir_step    = 1'b0;
        end else if (dir && (offset == offset_uplimit)) begin
            dir_step = 1'b0;
            if (offset_lowlimit != offset_uplimit) begin
                offset_step = offset - ADDR_W'(1);
            end
        end else if (!dir && (offset == offset_lowlimit)) begin
            dir_step = 1'b1;
            if (offset_lowlimit != offset_uplimit) begin
                offset_step = offset + ADDR_W'(1);
            end
        end else if (dir) begin
            offset_step = offset + ADDR_W'(1);
        end else begin
            offset_step = offset - ADDR_W'(1);
        end
    end

    // Sequencer: one state per clock, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            sample       <= '0;
            wr_ptr       <= '0;
            div_cnt      <= '0;
            dir          <= 1'b0;
            offset       <= '0;
            we_a         <= 1'b0;
            adr_a        <= '0;
            dat_a        <= '0;
            adr_b        <= '0;
            realt        <= '0;
            delay1       <= '0;
            delay2       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;

            // A new sample arriving mid-sequence is dropped, not queued.
            if (rise && enable && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (rise && enable) begin
                        sample <= data_adc;
                        state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    we_a  <= 1'b1;
                    adr_a <= wr_ptr;
                    dat_a <= sample;
                    realt <= sample;
                    state <= S_RD1;
                end
                S_RD1: begin
                    // Write lands on this edge, so a zero tap reads it back.
                    we_a  <= 1'b0;
                    adr_b <= wr_ptr - offset;
                    state <= S_RD2;
                end
                S_RD2: begin
                    adr_b <= wr_ptr - par_delay2;
                    state <= S_CAP1;
                end
                S_CAP1: begin
                    delay1 <= dat_b;
                    state  <= S_CAP2;
                end
                S_CAP2: begin
                    delay2       <= dat_b;
                    wr_ptr       <= wr_ptr + ADDR_W'(1);
                    sample_valid <= 1'b1;
                    if (div_cnt != sweep_div) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        offset  <= offset_step;
                        dir     <= dir_step;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flanger_ctrl.sv
// tb_flanger_ctrl: directed bench for flanger_ctrl with a behavioural
// dual-port RAM (1-cycle synchronous read) attached to ports A/B.
module tb_flanger_ctrl;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        data_rdy;
    logic [7:0]  data_adc;
    logic [12:0] par_delay2;
    logic [12:0] offset_lowlimit;
    logic [12:0] offset_uplimit;
    logic [15:0] sweep_div;
    logic        we_a;
    logic [12:0] adr_a;
    logic [7:0]  dat_a;
    logic [12:0] adr_b;
    logic [7:0]  dat_b;
    logic [7:0]  realt;
    logic [7:0]  delay1;
    logic [7:0]  delay2;
    logic [12:0] offset;
    logic        sample_valid;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem [8192];

    logic        o_busy, o_we1, o_we2, o_sv4, o_sv5;
    logic [12:0] o_adr_a, o_adr_b1, o_off;
    logic [7:0]  o_dat_a, o_realt, o_d1, o_d2;

    logic [12:0] sw_tbl [20] = '{13'd2, 13'd3, 13'd4, 13'd5, 13'd4, 13'd3, 13'd2,
                                 13'd3, 13'd4, 13'd5, 13'd4, 13'd3, 13'd2, 13'd3,
                                 13'd4, 13'd5, 13'd4, 13'd3, 13'd2, 13'd3};
    logic [12:0] div_tbl [6] = '{13'd0, 13'd0, 13'd2, 13'd2, 13'd2, 13'd3};

    flanger_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .data_rdy        (data_rdy),
        .data_adc        (data_adc),
        .par_delay2      (par_delay2),
        .offset_lowlimit (offset_lowlimit),
        .offset_uplimit  (offset_uplimit),
        .sweep_div       (sweep_div),
        .we_a            (we_a),
        .adr_a           (adr_a),
        .dat_a           (dat_a),
        .adr_b           (adr_b),
        .dat_b           (dat_b),
        .realt           (realt),
        .delay1          (delay1),
        .delay2          (delay2),
        .offset          (offset),
        .sample_valid    (sample_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural dual-port RAM: write on A, registered read on B.
    always @(posedge clk) begin
        if (we_a) mem[adr_a] <= dat_a;
        dat_b <= mem[adr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
    endtask

    // One full sample sequence; snapshots taken on negedges after N..N+5.
    task automatic do_sample(input logic [7:0] d);
        @(negedge clk); data_rdy = 1'b1; data_adc = d;
        @(negedge clk); data_rdy = 1'b0; o_busy = busy;
        @(negedge clk); o_we1 = we_a; o_adr_a = adr_a; o_dat_a = dat_a; o_realt = realt;
        @(negedge clk); o_we2 = we_a; o_adr_b1 = adr_b;
        @(negedge clk);
        @(negedge clk); o_sv4 = sample_valid;
        @(negedge clk); o_sv5 = sample_valid; o_d1 = delay1; o_d2 = delay2; o_off = offset;
    endtask

    initial begin
        int cnt_we, cnt_sv, cnt_act;
        logic [12:0] e;

        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        reset = 1'b1; enable = 1'b1; data_rdy = 1'b0; data_adc = 8'h00;
        par_delay2 = 13'd0; offset_lowlimit = 13'd2; offset_uplimit = 13'd5;
        sweep_div = 16'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_we_a", {31'd0, we_a}, 32'd0);
        chk("rst_adr", {6'd0, adr_a, adr_b}, 32'd0);
        chk("rst_data", {8'd0, realt, delay1, delay2}, 32'd0);
        chk("rst_offset", {19'd0, offset}, 32'd0);
        chk("rst_flags", {29'd0, sample_valid, busy, overrun}, 32'd0);

        // First sample: write path and latency.
        do_sample(8'h5A);
        chk("w_busy", {31'd0, o_busy}, 32'd1);
        chk("w_we_a", {31'd0, o_we1}, 32'd1);
        chk("w_adr_a", {19'd0, o_adr_a}, 32'd0);
        chk("w_dat_a", {24'd0, o_dat_a}, 32'h5A);
        chk("w_we_off", {31'd0, o_we2}, 32'd0);
        chk("w_sv_early", {31'd0, o_sv4}, 32'd0);
        chk("w_sv", {31'd0, o_sv5}, 32'd1);
        chk("w_realt", {24'd0, o_realt}, 32'h5A);
        chk("w_adr_b1", {19'd0, o_adr_b1}, 32'd0);
        chk("w_offset", {19'd0, o_off}, 32'd2);

        // Triangle sweep between 2 and 5, stepping every sample.
        for (int k = 1; k < 20; k++) begin
            do_sample(8'(k));
            chk("sw_offset", {19'd0, o_off}, {19'd0, sw_tbl[k]});
            e = 13'(k) - sw_tbl[k-1];
            chk("sw_adr_b1", {19'd0, o_adr_b1}, {19'd0, e});
            chk("sw_adr_a", {19'd0, o_adr_a}, k);
        end

        // Second rise 3 clk after accept is dropped and flagged.
        @(negedge clk); data_rdy = 1'b1; data_adc = 8'h77;
        @(negedge clk); data_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); data_rdy = 1'b1; data_adc = 8'h88;
        @(negedge clk); data_rdy = 1'b0;
        chk("ovr_pulse", {31'd0, overrun}, 32'd1);
        cnt_we = 0; cnt_sv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("ovr_one_clk", {31'd0, overrun}, 32'd0);
            cnt_we += int'(we_a);
            cnt_sv += int'(sample_valid);
        end
        chk("ovr_no_extra_we", cnt_we, 32'd0);
        chk("ovr_one_valid", cnt_sv, 32'd1);

        // Rise with enable low: nothing happens.
        enable = 1'b0;
        @(negedge clk); data_rdy = 1'b1;
        cnt_act = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) data_rdy = 1'b0;
            cnt_act += int'(we_a) + int'(overrun) + int'(busy);
        end
        chk("dis_no_activity", cnt_act, 32'd0);
        enable = 1'b1;
        do_sample(8'h99);
        chk("dis_adr_a", {19'd0, o_adr_a}, 32'd21);

        // Tap readback from a ramp.
        do_reset();
        par_delay2 = 13'd10; offset_lowlimit = 13'd7; offset_uplimit = 13'd7;
        for (int i = 0; i < 100; i++) do_sample(8'(i));
        do_sample(8'd100);
        chk("tap_realt", {24'd0, o_realt}, 32'd100);
        chk("tap_delay1", {24'd0, o_d1}, 32'd93);
        chk("tap_delay2", {24'd0, o_d2}, 32'd90);
        par_delay2 = 13'd0;
        do_sample(8'd101);
        chk("tap0_delay2", {24'd0, o_d2}, 32'd101);
        chk("tap0_delay1", {24'd0, o_d1}, 32'd94);

        // Reset asserted while in RD2 aborts the sequence.
        @(negedge clk); data_rdy = 1'b1; data_adc = 8'h33;
        @(negedge clk); data_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("mid_we_adr", {18'd0, we_a, adr_a}, 32'd0);
        chk("mid_adr_b", {19'd0, adr_b}, 32'd0);
        chk("mid_data", {dat_a, realt, delay1, delay2}, 32'd0);
        chk("mid_offset", {19'd0, offset}, 32'd0);
        chk("mid_flags", {29'd0, sample_valid, busy, overrun}, 32'd0);
        do_sample(8'h44);
        chk("mid_next_adr_a", {19'd0, o_adr_a}, 32'd0);
        chk("mid_next_dat_a", {24'd0, o_dat_a}, 32'h44);

        // Divider: offset steps every third sample.
        do_reset();
        offset_lowlimit = 13'd2; offset_uplimit = 13'd5; sweep_div = 16'd2;
        for (int k = 0; k < 6; k++) begin
            do_sample(8'(k));
            chk("div_offset", {19'd0, o_off}, {19'd0, div_tbl[k]});
        end

        // Inverted limits pin the offset at the lower limit.
        sweep_div = 16'd0; offset_lowlimit = 13'd6; offset_uplimit = 13'd4;
        do_sample(8'h10);
        chk("inv_offset", {19'd0, o_off}, 32'd6);
        do_sample(8'h11);
        chk("inv_offset_hold", {19'd0, o_off}, 32'd6);

        // Address wrap at the top of the delay line.
        do_reset();
        offset_lowlimit = 13'd3; offset_uplimit = 13'd3; par_delay2 = 13'd0;
        for (int i = 0; i < 8191; i++) do_sample(8'(i));
        do_sample(8'hAA);
        chk("wrap_adr_a", {19'd0, o_adr_a}, 32'h1FFF);
        chk("wrap_adr_b1", {19'd0, o_adr_b1}, 32'h1FFC);
        do_sample(8'hBB);
        chk("wrap_next_adr_a", {19'd0, o_adr_a}, 32'h0000);
        chk("wrap_next_adr_b1", {19'd0, o_adr_b1}, 32'h1FFD);
        chk("wrap_delay2", {24'd0, o_d2}, 32'hBB);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
